// File: rtl/matmul_pkg.sv
// Shared state encoding and sizing helpers for matmul_seq.
// MATMUL_SAT_EN adds the saturating narrow helper used by the MAC lanes.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Width of the intermediate used for the saturation compare.
  localparam int SAT_W = 128;

  function automatic int acc_width(input int n, input int depth);
    return 2 * n + $clog2(depth) + 1;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

`ifdef MATMUL_SAT_EN
  // Clamp a sign-extended value into the signed range of an n-bit word.
  function automatic logic signed [SAT_W-1:0] sat_narrow(input logic signed [SAT_W-1:0] v,
                                                         input int n);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (n - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
`endif

endpackage

// File: rtl/matmul_seq_mac_lane.sv
// One MAC lane: full-precision accumulator with clear/enable, plus the
// Q-shifted, narrowed result (wrap, or saturate under MATMUL_SAT_EN).
module mac_lane
  import matmul_pkg::*;
#(
  parameter int Q  = 15,
  parameter int N  = 32,
  parameter int d2 = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] narrow_o,
  output logic         ovf_o
);

  localparam int AW = acc_width(N, d2);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic [2*N-1:0]       prod;

  // Sign-extended operands make the low 2N bits of the product exact.
  assign prod = {{N{a_i[N-1]}}, a_i} * {{N{b_i[N-1]}}, b_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(AW-2*N){prod[2*N-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef MATMUL_SAT_EN
  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] clamped;

  always_comb begin
    wide     = SAT_W'(acc_q >>> Q);
    clamped  = sat_narrow(wide, N);
    narrow_o = clamped[N-1:0];
    ovf_o    = (clamped != wide);
  end
`else
  assign narrow_o = N'(acc_q >>> Q);
  assign ovf_o    = 1'b0;
`endif

endmodule

// File: rtl/matmul_seq.sv
// Time-multiplexed fixed-point matrix multiply with LANES MAC lanes per tile.
// Define MATMUL_SAT_EN for saturating narrowing with a sticky ovf flag.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int d1    = 5,
  parameter int d2    = 5,
  parameter int d3    = 5,
  parameter int LANES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [d1-1:0][d2-1:0][N-1:0]  matA,
  input  logic [d2-1:0][d3-1:0][N-1:0]  matB,
  output logic [d1-1:0][d3-1:0][N-1:0]  result,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output state_t                        dbg_state
);

  localparam int NG = ceil_div(d3, LANES);
  localparam int RW = (d1 > 1) ? $clog2(d1) : 1;
  localparam int KW = (d2 > 1) ? $clog2(d2) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int CW = (d3 > 1) ? $clog2(d3) : 1;
  localparam int XW = $clog2(NG * LANES + 1);

  state_t                         state_q;
  logic [RW-1:0]                  r_q;
  logic [GW-1:0]                  g_q;
  logic [KW-1:0]                  k_q;
  logic [d1-1:0][d2-1:0][N-1:0]   a_q;
  logic [d2-1:0][d3-1:0][N-1:0]   b_q;
  logic [d1-1:0][d3-1:0][N-1:0]   res_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           ovf_q;

  logic                    lane_clr;
  logic                    lane_en;
  logic [N-1:0]            lane_a;
  logic [LANES-1:0][N-1:0] lane_b;
  logic [LANES-1:0][N-1:0] lane_res;
  logic [LANES-1:0]        lane_ovf;
  logic [LANES-1:0]        lane_act;
  logic [LANES-1:0][CW-1:0] lane_col;

  assign lane_clr = (state_q == LOAD) || (state_q == WB);
  assign lane_en  = (state_q == MAC);
  assign lane_a   = a_q[r_q][k_q];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [XW-1:0] col;

    // Lanes whose column falls past d3 in the last group stay masked.
    assign col         = XW'(g_q) * XW'(LANES) + XW'(l);
    assign lane_act[l] = (col < XW'(d3));
    assign lane_col[l] = col[CW-1:0];
    assign lane_b[l]   = lane_act[l] ? b_q[k_q][lane_col[l]] : '0;

    mac_lane #(
      .Q  (Q),
      .N  (N),
      .d2 (d2)
    ) u_mac_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (lane_clr),
      .en_i     (lane_en),
      .a_i      (lane_a),
      .b_i      (lane_b[l]),
      .narrow_o (lane_res[l]),
      .ovf_o    (lane_ovf[l])
    );
  end

  // busy/done follow the state with one cycle of lag, so both are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      g_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      busy_q <= (state_q == LOAD) || (state_q == MAC) || (state_q == WB);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= matA;
            b_q     <= matB;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          r_q     <= '0;
          g_q     <= '0;
          k_q     <= '0;
          ovf_q   <= 1'b0;
          state_q <= MAC;
        end
        MAC: begin
          if (k_q == KW'(d2 - 1)) begin
            k_q     <= '0;
            state_q <= WB;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        WB: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_act[l]) begin
              res_q[r_q][lane_col[l]] <= lane_res[l];
              if (lane_ovf[l]) ovf_q <= 1'b1;
            end
          end
          if (g_q == GW'(NG - 1)) begin
            g_q <= '0;
            if (r_q == RW'(d1 - 1)) begin
              state_q <= DONE;
            end else begin
              r_q     <= r_q + 1'b1;
              state_q <= MAC;
            end
          end else begin
            g_q     <= g_q + 1'b1;
            state_q <= MAC;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result    = res_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: randomized jobs scored against a plain-arithmetic
// matrix product, plus directed identity, rounding, overflow, reset and start-ignore cases.
module tb_matmul_seq;
  import matmul_pkg::*;

  localparam int Q     = 15;
  localparam int N     = 32;
  localparam int D1    = 2;
  localparam int D2    = 3;
  localparam int D3    = 5;
  localparam int LN    = 2;
  localparam int NT    = D1 * ((D3 + LN - 1) / LN);
  localparam int LAT   = 2 + NT * (D2 + 1);
  localparam int RES_W = D1 * D3 * N;

  typedef logic [D1-1:0][D2-1:0][N-1:0] a_t;
  typedef logic [D2-1:0][D3-1:0][N-1:0] b_t;
  typedef logic [D1-1:0][D3-1:0][N-1:0] r_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT: non-square, last lane group partly masked
  logic   start = 1'b0;
  a_t     mat_a = '0;
  b_t     mat_b = '0;
  r_t     result;
  logic   busy, done, ovf;
  state_t dbg_state;

  matmul_seq #(.Q(Q), .N(N), .d1(D1), .d2(D2), .d3(D3), .LANES(LN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .matA      (mat_a),
    .matB      (mat_b),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // 2x2x2 instance for the identity/latency case
  logic                  start2 = 1'b0;
  logic [1:0][1:0][31:0] a2 = '0;
  logic [1:0][1:0][31:0] b2 = '0;
  logic [1:0][1:0][31:0] result2;
  logic                  busy2, done2, ovf2;
  state_t                dbg_state2;

  matmul_seq #(.Q(15), .N(32), .d1(2), .d2(2), .d3(2), .LANES(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .matA      (a2),
    .matB      (b2),
    .result    (result2),
    .busy      (busy2),
    .done      (done2),
    .ovf       (ovf2),
    .dbg_state (dbg_state2)
  );

  // scoreboard
  logic [RES_W:0] exp_q[$];
  int             lat_q[$];
  int             checks   = 0;
  int             failures = 0;

  task automatic check(input string nm, input logic [RES_W:0] act, input logic [RES_W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // reference: plain matrix product in wide integers, then >>> Q and narrow
  function automatic logic [RES_W:0] model(input a_t a, input b_t b);
    r_t                      r;
    logic                    o;
    logic signed [127:0]     s, ea, eb, sh, maxv, minv;
    logic signed [31:0]      pa, pb;
    o    = 1'b0;
    maxv = 128'sd2147483647;
    minv = -maxv - 128'sd1;
    for (int i = 0; i < D1; i++) begin
      for (int j = 0; j < D3; j++) begin
        s = '0;
        for (int k = 0; k < D2; k++) begin
          pa = a[i][k];
          pb = b[k][j];
          ea = pa;
          eb = pb;
          s  = s + ea * eb;
        end
        sh = s >>> Q;
`ifdef MATMUL_SAT_EN
        if (sh > maxv) begin
          r[i][j] = 32'h7FFFFFFF;
          o = 1'b1;
        end else if (sh < minv) begin
          r[i][j] = 32'h80000000;
          o = 1'b1;
        end else begin
          r[i][j] = sh[31:0];
        end
`else
        r[i][j] = sh[31:0];
`endif
      end
    end
    return {o, r};
  endfunction

  function automatic logic [31:0] rand_elem();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 262143)) - 32'd131072;
  endfunction

  function automatic a_t rand_a();
    a_t a;
    for (int i = 0; i < D1; i++) for (int k = 0; k < D2; k++) a[i][k] = rand_elem();
    return a;
  endfunction

  function automatic b_t rand_b();
    b_t b;
    for (int k = 0; k < D2; k++) for (int j = 0; j < D3; j++) b[k][j] = rand_elem();
    return b;
  endfunction

  function automatic a_t fill_a(input logic [31:0] v);
    a_t a;
    for (int i = 0; i < D1; i++) for (int k = 0; k < D2; k++) a[i][k] = v;
    return a;
  endfunction

  function automatic b_t fill_b(input logic [31:0] v);
    b_t b;
    for (int k = 0; k < D2; k++) for (int j = 0; j < D3; j++) b[k][j] = v;
    return b;
  endfunction

  // driver: present start when idle, then scramble the inputs
  task automatic issue(input a_t a, input b_t b);
    int t;
    t = 0;
    @(negedge clk);
    while (dbg_state != IDLE && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      fail_now("issue_timeout");
      return;
    end
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    lat_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    mat_a = rand_a();
    mat_b = rand_b();
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        fail_now("spurious_done");
      end else begin
        logic [RES_W:0] e;
        r_t             er;
        int             dc;
        e  = exp_q.pop_front();
        dc = lat_q.pop_front();
        er = e[RES_W-1:0];
        for (int i = 0; i < D1; i++)
          for (int j = 0; j < D3; j++)
            check($sformatf("res[%0d][%0d]", i, j), result[i][j], er[i][j]);
        check("ovf", ovf, e[RES_W]);
        check("done_cycle", cyc, dc);
        check("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    int t;
    int c0;
    a_t a;
    b_t b;

    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state_idle", dbg_state == IDLE, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // identity x B on the 2x2 instance, exact latency of 8 edges
    a2[0][0] = 32'd32768;  a2[0][1] = 32'd0;
    a2[1][0] = 32'd0;      a2[1][1] = 32'd32768;
    b2[0][0] = 32'd32768;  b2[0][1] = 32'd65536;
    b2[1][0] = 32'hFFFFC000; b2[1][1] = 32'd98304;
    start2 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start2 = 1'b0;
    a2 = '0;
    t = 0;
    while (!done2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!done2) fail_now("ident_timeout");
    check("ident_latency", cyc, c0 + 1 + 8);
    check("ident_r00", result2[0][0], 32'd32768);
    check("ident_r01", result2[0][1], 32'd65536);
    check("ident_r10", result2[1][0], 32'hFFFFC000);
    check("ident_r11", result2[1][1], 32'd98304);

    // all 0.5 x all 2.0 -> every entry 3.0
    issue(fill_a(32'd16384), fill_b(32'd65536));

    // sign/rounding: -1 raw * 1 raw -> -1 raw
    a = '0; b = '0;
    a[0][0] = 32'hFFFFFFFF;
    b[0][0] = 32'd1;
    issue(a, b);

    // overflow, then a small job must clear ovf
    issue(fill_a(32'd983040000), fill_b(32'd983040000));
    issue(fill_a(32'd32768), fill_b(32'hFFFF8000));

    // start pulses while busy and in DONE are ignored
    issue(rand_a(), rand_b());
    repeat (4) @(negedge clk);
    mat_a = rand_a();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (dbg_state != DONE && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_done_state", dbg_state == DONE, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("start_in_done_ignored", busy, 0);

    // reset in the middle of MAC abandons the job
    issue(rand_a(), rand_b());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_result", result, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ovf", ovf, 0);
    issue(fill_a(32'd16384), fill_b(32'd65536));

    repeat (20) issue(rand_a(), rand_b());

    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
